// File: rtl/alu_sout_tx.sv
// rtl/alu_sout_tx.sv - serial result/error packet transmitter driving the sout line
// Optional one-bit inter-frame gap: define SOUT_IFG_EN.
module alu_sout_tx #(
    parameter int BIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] c_data,
    input  logic [3:0]  alu_flags,
    input  logic [5:0]  err_flags,
    output logic        sout,
    output logic        tx_done
);
    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_CTL, S_GAP} state_t;

    state_t        r_state, w_state_n;
    logic [31:0]   r_data;
    logic [3:0]    r_flags;
    logic [5:0]    r_err;
    logic [1:0]    r_byte, w_byte_n;
    logic [3:0]    r_bit, w_bit_n;
    logic [CW-1:0] r_cyc, w_cyc_n;
    logic          r_sout, w_sout_n;
    logic          r_done, w_done_n;
    logic          w_load;
    logic          w_bit_end;
    logic [2:0]    w_crc;
    logic [7:0]    w_byte_pl, w_ctl_pl, w_payload;
`ifdef SOUT_IFG_EN
    state_t        r_nxt, w_nxt_n;
`endif

    // Remainder of {c_data, 0, flags} * x^3 modulo x^3+x+1, long division MSB first.
    function automatic logic [2:0] crc3(input logic [31:0] d, input logic [3:0] f);
        logic [39:0] m;
        logic [2:0]  r;
        logic        fb;
        m = {d, 1'b0, f, 3'b000};
        r = 3'b000;
        for (int i = 39; i >= 0; i--) begin
            fb = r[2];
            r  = {r[1:0], m[i]};
            if (fb) r = r ^ 3'b011;
        end
        return r;
    endfunction

    function automatic logic frame_bit(input logic typ, input logic [7:0] pl, input logic [3:0] idx);
        logic [3:0] j;
        j = 4'd9 - idx;
        case (idx)
            4'd0:    return 1'b0;
            4'd1:    return typ;
            4'd10:   return 1'b1;
            default: return (idx > 4'd10) ? 1'b1 : pl[j[2:0]];
        endcase
    endfunction

    always_comb begin
        case (r_byte)
            2'd0:    w_byte_pl = r_data[31:24];
            2'd1:    w_byte_pl = r_data[23:16];
            2'd2:    w_byte_pl = r_data[15:8];
            default: w_byte_pl = r_data[7:0];
        endcase
    end

    assign w_crc     = crc3(r_data, r_flags);
    assign w_ctl_pl  = (r_err != 6'd0) ? {1'b1, r_err, ^{1'b1, r_err}} : {1'b0, r_flags, w_crc};
    assign w_payload = (r_state == S_DATA) ? w_byte_pl : w_ctl_pl;
    assign w_bit_end = (r_cyc == CW'(BIT_CYCLES - 1));

    always_comb begin
        w_state_n = r_state;
        w_sout_n  = r_sout;
        w_bit_n   = r_bit;
        w_cyc_n   = r_cyc;
        w_byte_n  = r_byte;
        w_done_n  = 1'b0;
        w_load    = 1'b0;
`ifdef SOUT_IFG_EN
        w_nxt_n   = r_nxt;
`endif
        case (r_state)
            S_IDLE: begin
                w_sout_n = 1'b1;
                if (req_valid) begin
                    w_load    = 1'b1;
                    w_state_n = (err_flags != 6'd0) ? S_CTL : S_DATA;
                    w_sout_n  = 1'b0;
                    w_bit_n   = 4'd0;
                    w_cyc_n   = '0;
                    w_byte_n  = 2'd0;
                end
            end
            S_DATA, S_CTL: begin
                if (!w_bit_end) begin
                    w_cyc_n = r_cyc + 1'b1;
                end else begin
                    w_cyc_n = '0;
                    if (r_bit != 4'd10) begin
                        w_bit_n  = r_bit + 4'd1;
                        w_sout_n = frame_bit(r_state == S_CTL, w_payload, r_bit + 4'd1);
                    end else begin
                        w_bit_n = 4'd0;
`ifdef SOUT_IFG_EN
                        w_state_n = S_GAP;
                        w_sout_n  = 1'b1;
                        if (r_state == S_DATA) begin
                            w_byte_n = r_byte + 2'd1;
                            w_nxt_n  = (r_byte == 2'd3) ? S_CTL : S_DATA;
                        end else begin
                            w_nxt_n  = S_IDLE;
                        end
`else
                        // Next start bit is loaded on the same edge so frames abut.
                        if (r_state == S_DATA) begin
                            w_sout_n = 1'b0;
                            if (r_byte == 2'd3) w_state_n = S_CTL;
                            else                w_byte_n  = r_byte + 2'd1;
                        end else begin
                            w_state_n = S_IDLE;
                            w_sout_n  = 1'b1;
                            w_done_n  = 1'b1;
                        end
`endif
                    end
                end
            end
`ifdef SOUT_IFG_EN
            S_GAP: begin
                w_sout_n = 1'b1;
                if (!w_bit_end) begin
                    w_cyc_n = r_cyc + 1'b1;
                end else begin
                    w_cyc_n   = '0;
                    w_state_n = r_nxt;
                    if (r_nxt == S_IDLE) w_done_n = 1'b1;
                    else                 w_sout_n = 1'b0;
                end
            end
`endif
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sout  <= 1'b1;
            r_done  <= 1'b0;
            r_bit   <= 4'd0;
            r_cyc   <= '0;
            r_byte  <= 2'd0;
            r_data  <= 32'd0;
            r_flags <= 4'd0;
            r_err   <= 6'd0;
`ifdef SOUT_IFG_EN
            r_nxt   <= S_IDLE;
`endif
        end else begin
            r_state <= w_state_n;
            r_sout  <= w_sout_n;
            r_done  <= w_done_n;
            r_bit   <= w_bit_n;
            r_cyc   <= w_cyc_n;
            r_byte  <= w_byte_n;
`ifdef SOUT_IFG_EN
            r_nxt   <= w_nxt_n;
`endif
            if (w_load) begin
                r_data  <= c_data;
                r_flags <= alu_flags;
                r_err   <= err_flags;
            end
        end
    end

    assign sout      = r_sout;
    assign tx_done   = r_done;
    assign req_ready = (r_state == S_IDLE);
endmodule

// File: tb/tb_alu_sout_tx.sv
// tb/tb_alu_sout_tx.sv - directed self-checking bench for alu_sout_tx
module tb_alu_sout_tx;
`ifdef SOUT_IFG_EN
    localparam int GAPB = 1;
`else
    localparam int GAPB = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rv1 = 1'b0, rv4 = 1'b0;
    logic [31:0] c_data = '0;
    logic [3:0]  alu_flags = '0;
    logic [5:0]  err_flags = '0;
    logic        rdy1, sout1, done1, rdy4, sout4, done4;

    int checks = 0;
    int failures = 0;

    bit   exp_s[$];
    bit   exp_d[$];
    logic obs_s[$];
    logic obs_d[$];
    logic obs_r[$];

    alu_sout_tx #(.BIT_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .req_valid(rv1), .req_ready(rdy1),
        .c_data(c_data), .alu_flags(alu_flags), .err_flags(err_flags),
        .sout(sout1), .tx_done(done1)
    );

    alu_sout_tx #(.BIT_CYCLES(4)) u4 (
        .clk(clk), .rst(rst), .req_valid(rv4), .req_ready(rdy4),
        .c_data(c_data), .alu_flags(alu_flags), .err_flags(err_flags),
        .sout(sout4), .tx_done(done4)
    );

    always #5 clk = ~clk;

    // x^n mod x^3+x+1 repeats with period 7
    function automatic logic [2:0] xpow(input int n);
        case (n % 7)
            0: return 3'b001;
            1: return 3'b010;
            2: return 3'b100;
            3: return 3'b011;
            4: return 3'b110;
            5: return 3'b111;
            default: return 3'b101;
        endcase
    endfunction

    function automatic logic [2:0] crc_model(input logic [31:0] c, input logic [3:0] f);
        logic [2:0] r;
        r = 3'b000;
        for (int j = 0; j < 32; j++) if (c[j]) r = r ^ xpow(j + 8);
        for (int k = 0; k < 4; k++)  if (f[k]) r = r ^ xpow(k + 3);
        return r;
    endfunction

    task automatic add_frame(input bit typ, input logic [7:0] pl, input int bc);
        logic [10:0] fr;
        fr = {1'b0, typ, pl, 1'b1};
        for (int b = 10; b >= 0; b--)
            for (int k = 0; k < bc; k++) begin exp_s.push_back(fr[b]); exp_d.push_back(1'b0); end
        for (int k = 0; k < GAPB * bc; k++) begin exp_s.push_back(1'b1); exp_d.push_back(1'b0); end
    endtask

    task automatic add_done();
        exp_s.push_back(1'b1);
        exp_d.push_back(1'b1);
    endtask

    task automatic add_result(input logic [31:0] c, input logic [3:0] f, input int bc);
        add_frame(1'b0, c[31:24], bc);
        add_frame(1'b0, c[23:16], bc);
        add_frame(1'b0, c[15:8], bc);
        add_frame(1'b0, c[7:0], bc);
        add_frame(1'b1, {1'b0, f, crc_model(c, f)}, bc);
    endtask

    task automatic start_req(input bit sel, input logic [31:0] c, input logic [3:0] f, input logic [5:0] e);
        @(negedge clk);
        c_data = c; alu_flags = f; err_flags = e;
        if (sel) rv4 = 1'b1; else rv1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Samples n cycles from the current negedge; scrambles inputs after acceptance.
    task automatic capture(input bit sel, input int n, input int drop_at,
                           input logic [31:0] nc, input logic [3:0] nf, input logic [5:0] ne);
        obs_s.delete(); obs_d.delete(); obs_r.delete();
        for (int k = 0; k < n; k++) begin
            obs_s.push_back(sel ? sout4 : sout1);
            obs_d.push_back(sel ? done4 : done1);
            obs_r.push_back(sel ? rdy4 : rdy1);
            if (k == drop_at) begin if (sel) rv4 = 1'b0; else rv1 = 1'b0; end
            if (k == 1) begin c_data = nc; alu_flags = nf; err_flags = ne; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (sout1 !== 1'b1) begin failures++; $display("FAIL reset_sout1 got %b want 1", sout1); end
        checks++; if (rdy1 !== 1'b1)  begin failures++; $display("FAIL reset_ready1 got %b want 1", rdy1); end
        checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL reset_done1 got %b want 0", done1); end
        checks++; if (sout4 !== 1'b1) begin failures++; $display("FAIL reset_sout4 got %b want 1", sout4); end
        checks++; if (rdy4 !== 1'b1)  begin failures++; $display("FAIL reset_ready4 got %b want 1", rdy4); end
        checks++; if (done4 !== 1'b0) begin failures++; $display("FAIL reset_done4 got %b want 0", done4); end
        rst = 1'b0;
    endtask

    task automatic test_result_basic();
        int bad = 0;
        int di = -1;
        exp_s.delete(); exp_d.delete();
        add_frame(1'b0, 8'h12, 1);
        add_frame(1'b0, 8'h34, 1);
        add_frame(1'b0, 8'h56, 1);
        add_frame(1'b0, 8'h78, 1);
        add_frame(1'b1, {1'b0, 4'b0000, crc_model(32'h12345678, 4'b0000)}, 1);
        add_done();
        start_req(1'b0, 32'h12345678, 4'b0000, 6'd0);
        capture(1'b0, exp_s.size(), 0, 32'hFFFF_FFFF, 4'hF, 6'h3F);
        checks++;
        for (int i = 0; i < exp_s.size(); i++) begin
            if (obs_s[i] !== exp_s[i] || obs_d[i] !== exp_d[i] || obs_r[i] !== exp_d[i]) begin
                if (bad < 3) $display("FAIL result_basic cycle %0d sout/done/ready=%b%b%b want %b%b%b",
                                      i, obs_s[i], obs_d[i], obs_r[i], exp_s[i], exp_d[i], exp_d[i]);
                bad++;
            end
            if (di < 0 && obs_d[i] === 1'b1) di = i;
        end
        if (bad != 0) failures++;
        checks++;
        if (di != 55 + 5 * GAPB) begin
            failures++; $display("FAIL result_basic_done_pos got %0d want %0d", di, 55 + 5 * GAPB);
        end
    endtask

    task automatic test_result_zero();
        int bad = 0;
        exp_s.delete(); exp_d.delete();
        for (int b = 0; b < 4; b++) add_frame(1'b0, 8'h00, 1);
        add_frame(1'b1, 8'h16, 1);
        add_done();
        start_req(1'b0, 32'h0, 4'b0010, 6'd0);
        capture(1'b0, exp_s.size(), exp_s.size() - 1, 32'hA5A5_A5A5, 4'b1101, 6'h01);
        checks++;
        for (int i = 0; i < exp_s.size(); i++)
            if (obs_s[i] !== exp_s[i] || obs_d[i] !== exp_d[i] || obs_r[i] !== exp_d[i]) begin
                if (bad < 3) $display("FAIL result_zero cycle %0d sout/done/ready=%b%b%b want %b%b%b",
                                      i, obs_s[i], obs_d[i], obs_r[i], exp_s[i], exp_d[i], exp_d[i]);
                bad++;
            end
        if (bad != 0) failures++;
    endtask

    task automatic test_error_single();
        int bad = 0;
        int di = -1;
        exp_s.delete(); exp_d.delete();
        add_frame(1'b1, 8'h93, 1);
        add_done();
        start_req(1'b0, 32'hCAFE_F00D, 4'b1111, 6'b001001);
        capture(1'b0, exp_s.size(), exp_s.size() - 1, 32'h0, 4'h0, 6'h00);
        checks++;
        for (int i = 0; i < exp_s.size(); i++) begin
            if (obs_s[i] !== exp_s[i] || obs_d[i] !== exp_d[i] || obs_r[i] !== exp_d[i]) begin
                if (bad < 3) $display("FAIL error_single cycle %0d sout/done/ready=%b%b%b want %b%b%b",
                                      i, obs_s[i], obs_d[i], obs_r[i], exp_s[i], exp_d[i], exp_d[i]);
                bad++;
            end
            if (di < 0 && obs_d[i] === 1'b1) di = i;
        end
        if (bad != 0) failures++;
        checks++;
        if (di != 11 + GAPB) begin
            failures++; $display("FAIL error_single_done_pos got %0d want %0d", di, 11 + GAPB);
        end
    endtask

    task automatic test_error_pair();
        logic [5:0] errs [2];
        logic [7:0] pls  [2];
        errs[0] = 6'b100100; pls[0] = 8'hC9;
        errs[1] = 6'b010010; pls[1] = 8'hA5;
        for (int t = 0; t < 2; t++) begin
            int bad = 0;
            exp_s.delete(); exp_d.delete();
            add_frame(1'b1, pls[t], 1);
            add_done();
            start_req(1'b0, 32'h1357_9BDF, 4'b1010, errs[t]);
            capture(1'b0, exp_s.size(), 0, 32'h2468_ACE0, 4'b0101, 6'h00);
            checks++;
            for (int i = 0; i < exp_s.size(); i++)
                if (obs_s[i] !== exp_s[i] || obs_d[i] !== exp_d[i] || obs_r[i] !== exp_d[i]) begin
                    if (bad < 3) $display("FAIL error_pair%0d cycle %0d sout/done/ready=%b%b%b want %b%b%b",
                                          t, i, obs_s[i], obs_d[i], obs_r[i], exp_s[i], exp_d[i], exp_d[i]);
                    bad++;
                end
            if (bad != 0) failures++;
        end
    endtask

    task automatic test_mid_reset();
        int bad = 0;
        start_req(1'b0, 32'h12345678, 4'b0000, 6'd0);
        capture(1'b0, 20, 0, 32'h0, 4'h0, 6'h0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (sout1 !== 1'b1) begin failures++; $display("FAIL midreset_sout got %b want 1", sout1); end
        checks++; if (rdy1 !== 1'b1)  begin failures++; $display("FAIL midreset_ready got %b want 1", rdy1); end
        checks++; if (done1 !== 1'b0) begin failures++; $display("FAIL midreset_done got %b want 0", done1); end
        capture(1'b0, 60, -1, 32'h0, 4'h0, 6'h0);
        checks++;
        for (int i = 0; i < 60; i++)
            if (obs_s[i] !== 1'b1 || obs_d[i] !== 1'b0) begin
                if (bad < 3) $display("FAIL midreset_idle cycle %0d sout=%b done=%b want 1 0", i, obs_s[i], obs_d[i]);
                bad++;
            end
        if (bad != 0) failures++;
        bad = 0;
        exp_s.delete(); exp_d.delete();
        add_result(32'hDEADBEEF, 4'b1111, 1);
        add_done();
        start_req(1'b0, 32'hDEADBEEF, 4'b1111, 6'd0);
        capture(1'b0, exp_s.size(), 0, 32'h0, 4'h0, 6'h2A);
        checks++;
        for (int i = 0; i < exp_s.size(); i++)
            if (obs_s[i] !== exp_s[i] || obs_d[i] !== exp_d[i] || obs_r[i] !== exp_d[i]) begin
                if (bad < 3) $display("FAIL midreset_next cycle %0d sout/done/ready=%b%b%b want %b%b%b",
                                      i, obs_s[i], obs_d[i], obs_r[i], exp_s[i], exp_d[i], exp_d[i]);
                bad++;
            end
        if (bad != 0) failures++;
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        int first_done;
        exp_s.delete(); exp_d.delete();
        add_result(32'hA5C3_0F81, 4'b1001, 4);
        first_done = exp_s.size();
        add_done();
        add_result(32'h0000_00FF, 4'b0100, 4);
        add_done();
        start_req(1'b1, 32'hA5C3_0F81, 4'b1001, 6'd0);
        capture(1'b1, exp_s.size(), first_done + 1, 32'h0000_00FF, 4'b0100, 6'd0);
        checks++;
        if (first_done != (55 + 5 * GAPB) * 4) begin
            failures++; $display("FAIL b2b_len got %0d want %0d", first_done, (55 + 5 * GAPB) * 4);
        end
        checks++;
        for (int i = 0; i < exp_s.size(); i++)
            if (obs_s[i] !== exp_s[i] || obs_d[i] !== exp_d[i] || obs_r[i] !== exp_d[i]) begin
                if (bad < 3) $display("FAIL b2b_stream cycle %0d sout/done/ready=%b%b%b want %b%b%b",
                                      i, obs_s[i], obs_d[i], obs_r[i], exp_s[i], exp_d[i], exp_d[i]);
                bad++;
            end
        if (bad != 0) failures++;
        bad = 0;
        capture(1'b1, 12, -1, 32'h0, 4'h0, 6'h0);
        checks++;
        for (int i = 0; i < 12; i++)
            if (obs_s[i] !== 1'b1 || obs_d[i] !== 1'b0 || obs_r[i] !== 1'b1) begin
                if (bad < 3) $display("FAIL b2b_after cycle %0d sout/done/ready=%b%b%b want 101",
                                      i, obs_s[i], obs_d[i], obs_r[i]);
                bad++;
            end
        if (bad != 0) failures++;
    endtask

    initial begin
        test_reset();
        test_result_basic();
        test_result_zero();
        test_error_single();
        test_error_pair();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_sout_tx.md
Name: alu_sout_tx

Overview:
Serial response transmitter for the ALU: the sending end of the sout line that the scoreboard decodes.
- Accepts one result (C data, ALU flags) or error status per request.
- Computes CRC-3 / parity and serializes a result packet (4 DATA frames + 1 CTL frame) or an error packet (1 CTL frame).
- Sits between the ALU datapath and the sout pin; the datapath drives the request handshake.

Parameters:
BIT_CYCLES, 1, clock cycles per serial bit (>=1).

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active high
req_valid  in  1  request present
req_ready  out  1  transmitter can accept a request
c_data  in  32  result word C
alu_flags  in  4  {CARRY, OVERFLOW, ZERO, NEGATIVE}
err_flags  in  6  {ERR_DATA, ERR_CRC, ERR_OP, ERR_DATA, ERR_CRC, ERR_OP}
sout  out  1  serial output, idle high
tx_done  out  1  one-cycle pulse, packet fully sent

Behaviour:
- Reset (one clk edge with rst=1): sout=1, req_ready=1, tx_done=0, state IDLE, all counters 0. Reset mid-packet aborts immediately; sout=1 after that edge; no tx_done for the aborted packet.
- Handshake: transfer when req_valid & req_ready on a rising edge. Inputs are sampled only at that edge and registered. req_ready=1 only in IDLE; req_valid while busy is ignored, not queued.
- Frame (11 bits, MSB first): start 0, type (0=DATA, 1=CTL), D7..D0, stop 1. Each bit is held for BIT_CYCLES clocks. sout is registered: first start bit appears in the cycle after acceptance.
- Packet selection by registered err_flags:
  - err_flags != 0 -> error packet: one CTL frame, payload {1, err_flags, P}, P = ^{1'b1, err_flags}.
  - err_flags == 0 -> result packet: 4 DATA frames c_data[31:24], [23:16], [15:8], [7:0], then one CTL frame with payload {0, alu_flags, CRC3}.
- CRC3: polynomial x^3+x+1, init 000, computed over the 37-bit message {c_data, 1'b0, alu_flags}, MSB first, with 3 zero bits appended (remainder of M(x)*x^3). Computed once from the registered fields, before the CTL frame starts. Must not add idle bits.
- FSM states:
  - IDLE: sout=1. On accept -> DATA if error-free, else CTL.
  - DATA: byte index 0..3. After the stop bit of byte 3 -> CTL.
  - CTL: after its stop bit -> IDLE.
  - Internal counters: bit counter 0..10, cycle counter 0..BIT_CYCLES-1; both wrap to 0 at frame end.
- Packet length: result = 55*BIT_CYCLES clocks, error = 11*BIT_CYCLES clocks, counted from the first start-bit cycle.
- Completion: tx_done pulses for one cycle in the cycle after the last stop-bit period. req_ready=1 in that same cycle. A request accepted in that cycle starts its start bit in the next cycle, giving back-to-back packets with no idle bit.
- Output integrity: sout never glitches between bits. Inputs changing after acceptance do not affect the packet in flight.

Optional Feature:
Macro: SOUT_IFG_EN.
- Defined: GAP state inserted after every frame's stop bit (DATA->DATA, DATA->CTL, and CTL->IDLE). sout=1 for one bit period (BIT_CYCLES clocks). tx_done and req_ready follow the gap after the CTL frame. Result packet = 60*BIT_CYCLES, error packet = 12*BIT_CYCLES.
- Undefined: no GAP state; frames strictly back-to-back.

Test Plan:
1. BIT_CYCLES=1, c_data=32'h12345678, flags=4'b0000, err=0:
   - sout = frames 0_0_00010010_1, 0_0_00110100_1, 0_0_01010110_1, 0_0_01111000_1, then CTL 0_1_<0,0000,CRC3>_1, CRC3 matching the bench model.
   - tx_done 55 cycles after the first start bit.
2. c_data=0, flags=4'b0010 (ZERO), err=0 -> four DATA frames with payload 8'h00; CTL payload 8'h16 (CRC3=3'b110).
3. err_flags=6'b001001 -> single CTL frame payload 8'h93 (parity 1); no DATA frames; tx_done after 11 bits.
4. err_flags=6'b100100 and 6'b010010 -> CTL payloads 8'hC9 and 8'hA5; c_data/flags ignored.
5. rst asserted at bit 20 of a result packet:
   - sout=1 and req_ready=1 next cycle; no tx_done.
   - A new request then transmits correctly from its start bit.
6. BIT_CYCLES=4, req_valid held high with two queued results:
   - Each bit lasts 4 clocks.
   - Second packet's start bit immediately follows the first packet's stop bit (or a 4-clock gap with SOUT_IFG_EN).
   - req_valid during busy is not accepted.
